counter_scheduler: RTL

Time-shares one external 8-bit enable/clear counter among `NUM_REQ` requesters; each requester asks for a counting window of a programmed length. The scheduler arbitrates round-robin, clears the counter, gates its enable for exactly the requested number of increments, then pulses `done` to the winner. It sits between the requesting control blocks and the counter datapath, and is the only driver of that counter's enable and clear.

---
 rtl/counter_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/counter_scheduler.sv | 89 ++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared types and constants for the counter scheduler
package counter_sched_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } sched_state_t;

    localparam int MAX_REQ           = 8;
    localparam int CNT_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: masked round-robin pick, searching from the requester after last_i
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o
);
    // walk the ring once starting just past the last grantee; first eligible wins
    always_comb begin
        int j;
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_i) + k) % NUM_REQ;
            if (!valid_o && req_i[j] && mask_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-sharing of one external enable/clear counter
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic                         cnt_clear,
    output logic                         cnt_enable,
    input  logic [CNT_WIDTH-1:0]         cnt_value
);
    localparam int                   IDX_W   = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0]   ONE_HOT = NUM_REQ'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    sched_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [IDX_W-1:0]     owner_q, owner_d, last_q, last_d, win_idx;
    logic [NUM_REQ-1:0]   owner_oh, arb_mask, arb_gnt;
    logic                 arb_valid;

    assign owner_oh = ONE_HOT << owner_q;
    // in DONE the finishing owner may not win again immediately
    assign arb_mask = (state_q == S_DONE) ? ~owner_oh : '1;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req),
        .mask_i  (arb_mask),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    // one-hot winner back to an index for the owner and pointer registers
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_gnt[i]) win_idx = IDX_W'(i);
    end

    // window sequencing: arbitrate in IDLE/DONE, abort when the owner drops req
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = arb_valid ? S_CLEAR : S_IDLE;
                if (arb_valid) begin
                    len_d   = req_len[int'(win_idx)*CNT_WIDTH +: CNT_WIDTH];
                    owner_d = win_idx;
                    last_d  = win_idx;
                end
            end
            S_CLEAR: state_d = !req[owner_q] ? S_IDLE : (len_q == '0) ? S_DONE : S_RUN;
            S_RUN:   state_d = !req[owner_q] ? S_IDLE : (cnt_value == len_q - CNT_ONE) ? S_DONE : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // state, latched length/owner, and round-robin pointer (starts so requester 0 leads)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign gnt        = (state_q != S_IDLE) ? owner_oh : '0;
    assign done       = (state_q == S_DONE) ? owner_oh : '0;
    assign busy       = state_q != S_IDLE;
    assign cnt_clear  = state_q == S_CLEAR;
    assign cnt_enable = state_q == S_RUN;
endmodule
